// File: rtl/phy_rx_link_ctrl.sv
// Two-lane PHY RX link training controller: per-lane COM lock, lane alignment and link-loss detection.
// Defining PHY_RX_LINK_ERR_CNT_EN builds the saturating link-loss event counter behind err_count.
module phy_rx_link_ctrl #(
  parameter logic [7:0]  COM_SYM   = 8'hBC,
  parameter int unsigned LOCK_CNT  = 4,
  parameter int unsigned LOSS_CNT  = 4,
  parameter int unsigned ALIGN_TMO = 255
) (
  input  logic       clk_4f,
  input  logic       reset,
  input  logic       enable,
  input  logic [7:0] data_8b_0,
  input  logic       valid_8b_0,
  input  logic [7:0] data_8b_1,
  input  logic       valid_8b_1,
  output logic       sincronizar_bus,
  output logic       link_up,
  output logic [1:0] lane_lock,
  output logic [2:0] ctrl_state,
  output logic [7:0] err_count
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SEARCH = 3'd1,
    ST_ALIGN  = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_LOSS   = 3'd4
  } state_e;

  localparam logic [3:0] LOCK_MAX = 4'(LOCK_CNT);
  localparam logic [3:0] LOSS_MAX = 4'(LOSS_CNT);
  localparam logic [7:0] TMO_MAX  = 8'(ALIGN_TMO);

  state_e     state_q, state_d;
  logic [3:0] lk0_q, lk0_d, lk1_q, lk1_d;
  logic [3:0] lk0_upd, lk1_upd;
  logic [7:0] tmo_q, tmo_d;
  logic [3:0] mm_q, mm_d;
  logic       link_up_q;
  logic       com_0, com_1;

  // Lock counter rule: COM counts up (saturating), a valid non-COM byte restarts, an idle cycle holds.
  function automatic logic [3:0] lock_next(input logic [3:0] lk, input logic vld, input logic com);
    if (com)      return (lk == LOCK_MAX) ? lk : lk + 4'd1;
    else if (vld) return 4'd0;
    else          return lk;
  endfunction

  assign com_0   = valid_8b_0 && (data_8b_0 == COM_SYM);
  assign com_1   = valid_8b_1 && (data_8b_1 == COM_SYM);
  assign lk0_upd = lock_next(lk0_q, valid_8b_0, com_0);
  assign lk1_upd = lock_next(lk1_q, valid_8b_1, com_1);

  // NOTE: every always_comb target gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    lk0_d   = lk0_q;
    lk1_d   = lk1_q;
    tmo_d   = tmo_q;
    mm_d    = mm_q;

    unique case (state_q)
      ST_IDLE: begin
        if (enable) state_d = ST_SEARCH;
      end
      ST_SEARCH: begin
        lk0_d = lk0_upd;
        lk1_d = lk1_upd;
        if (lane_lock == 2'b11) begin
          state_d = ST_ALIGN;
          tmo_d   = 8'd0;
        end
      end
      ST_ALIGN: begin
        lk0_d = lk0_upd;
        lk1_d = lk1_upd;
        if (com_0 && com_1) begin
          state_d = ST_ACTIVE;
          tmo_d   = 8'd0;
        end else if (lk0_upd != LOCK_MAX || lk1_upd != LOCK_MAX) begin
          state_d = ST_SEARCH;
          tmo_d   = 8'd0;
        end else if (tmo_q + 8'd1 == TMO_MAX) begin
          state_d = ST_SEARCH;
          tmo_d   = 8'd0;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      ST_ACTIVE: begin
        if (valid_8b_0 != valid_8b_1) begin
          if (mm_q + 4'd1 == LOSS_MAX) begin
            state_d = ST_LOSS;
            mm_d    = 4'd0;
          end else begin
            mm_d = mm_q + 4'd1;
          end
        end else begin
          mm_d = 4'd0;
        end
      end
      ST_LOSS: begin
        state_d = ST_SEARCH;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Enable overrides every other transition, including a same-cycle loss decision.
    if (!enable) begin
      state_d = ST_IDLE;
      tmo_d   = 8'd0;
      mm_d    = 4'd0;
    end

    if (state_d == ST_IDLE || (state_d == ST_SEARCH && state_q != ST_SEARCH)) begin
      lk0_d = 4'd0;
      lk1_d = 4'd0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_4f or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      lk0_q     <= 4'd0;
      lk1_q     <= 4'd0;
      tmo_q     <= 8'd0;
      mm_q      <= 4'd0;
      link_up_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      lk0_q     <= lk0_d;
      lk1_q     <= lk1_d;
      tmo_q     <= tmo_d;
      mm_q      <= mm_d;
      link_up_q <= (state_d == ST_ACTIVE);
    end
  end

`ifdef PHY_RX_LINK_ERR_CNT_EN
  logic [7:0] err_q;
  logic       enter_loss;

  // Counted on entry to LOSS, so an enable drop that pre-empts the loss leaves it untouched.
  assign enter_loss = (state_d == ST_LOSS);

  always_ff @(posedge clk_4f or negedge reset) begin
    if (!reset) begin
      err_q <= 8'd0;
    end else if (enter_loss && err_q != 8'hFF) begin
      err_q <= err_q + 8'd1;
    end
  end

  assign err_count = err_q;
`else
  assign err_count = 8'h00;
`endif

  assign sincronizar_bus = (state_q == ST_ACTIVE);
  assign link_up         = link_up_q;
  assign lane_lock       = {(lk1_q == LOCK_MAX), (lk0_q == LOCK_MAX)};
  assign ctrl_state      = state_q;

endmodule

// File: tb/tb_phy_rx_link_ctrl.sv
// Self-checking bench for phy_rx_link_ctrl: directed training scenarios plus randomized traffic
// compared cycle by cycle against a rule-level reference model.
module tb_phy_rx_link_ctrl;

  localparam logic [7:0] COM       = 8'hBC;
  localparam int         LOCK_CNT  = 4;
  localparam int         LOSS_CNT  = 4;
  localparam int         ALIGN_TMO = 255;
`ifdef PHY_RX_LINK_ERR_CNT_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic       clk_4f = 1'b0;
  logic       reset;
  logic       enable;
  logic [7:0] data_8b_0, data_8b_1;
  logic       valid_8b_0, valid_8b_1;
  logic       sincronizar_bus, link_up;
  logic [1:0] lane_lock;
  logic [2:0] ctrl_state;
  logic [7:0] err_count;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: state as the documented encoding, counters as plain ints.
  int m_st;
  int m_lk [2];
  int m_tmo, m_mm, m_err;

  phy_rx_link_ctrl dut (
    .clk_4f          (clk_4f),
    .reset           (reset),
    .enable          (enable),
    .data_8b_0       (data_8b_0),
    .valid_8b_0      (valid_8b_0),
    .data_8b_1       (data_8b_1),
    .valid_8b_1      (valid_8b_1),
    .sincronizar_bus (sincronizar_bus),
    .link_up         (link_up),
    .lane_lock       (lane_lock),
    .ctrl_state      (ctrl_state),
    .err_count       (err_count)
  );

  always #5 clk_4f = ~clk_4f;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_lk[0] = 0; m_lk[1] = 0; m_tmo = 0; m_mm = 0; m_err = 0;
  endtask

  function automatic int lock_rule(input int lk, input bit v, input bit c);
    if (c) return (lk < LOCK_CNT) ? lk + 1 : LOCK_CNT;
    return v ? 0 : lk;
  endfunction

  task automatic ref_step(input bit en, input bit v0, input logic [7:0] d0,
                          input bit v1, input logic [7:0] d1);
    bit c0, c1, locked_before;
    int nxt;
    c0 = v0 && (d0 == COM);
    c1 = v1 && (d1 == COM);
    locked_before = (m_lk[0] == LOCK_CNT) && (m_lk[1] == LOCK_CNT);
    nxt = m_st;
    case (m_st)
      0: if (en) nxt = 1;
      1: begin
        m_lk[0] = lock_rule(m_lk[0], v0, c0);
        m_lk[1] = lock_rule(m_lk[1], v1, c1);
        if (locked_before) nxt = 2;
      end
      2: begin
        m_lk[0] = lock_rule(m_lk[0], v0, c0);
        m_lk[1] = lock_rule(m_lk[1], v1, c1);
        if (c0 && c1) nxt = 3;
        else if (m_lk[0] != LOCK_CNT || m_lk[1] != LOCK_CNT) nxt = 1;
        else begin
          m_tmo++;
          if (m_tmo >= ALIGN_TMO) nxt = 1;
        end
      end
      3: begin
        m_mm = (v0 != v1) ? m_mm + 1 : 0;
        if (m_mm >= LOSS_CNT) nxt = 4;
      end
      default: nxt = 1;
    endcase
    if (!en) nxt = 0;
    if (nxt == 4 && ERR_EN && m_err < 255) m_err++;
    if (nxt != m_st) begin
      m_tmo = 0;
      m_mm  = 0;
      if (nxt <= 1) begin m_lk[0] = 0; m_lk[1] = 0; end
    end
    m_st = nxt;
  endtask

  // Apply one byte pair, clock it, advance the model and compare every output.
  task automatic step(input bit en, input bit v0, input logic [7:0] d0,
                      input bit v1, input logic [7:0] d1);
    logic [14:0] exp_vec;
    enable = en; valid_8b_0 = v0; data_8b_0 = d0; valid_8b_1 = v1; data_8b_1 = d1;
    @(posedge clk_4f);
    ref_step(en, v0, d0, v1, d1);
    #1;
    exp_vec = {3'(m_st), (m_lk[1] == LOCK_CNT), (m_lk[0] == LOCK_CNT),
               (m_st == 3), (m_st == 3), 8'(m_err)};
    check("cycle", 32'({ctrl_state, lane_lock, sincronizar_bus, link_up, err_count}), 32'(exp_vec));
  endtask

  function automatic logic [7:0] rnd_byte();
    return 8'($urandom);
  endfunction

  // Brings the link from IDLE or SEARCH up to ACTIVE with in-phase COM pairs.
  task automatic train_to_active();
    if (m_st == 0) step(1, 0, 8'h00, 0, 8'h00);
    for (int i = 0; i < LOCK_CNT + 2; i++) step(1, 1, COM, 1, COM);
  endtask

  task automatic force_loss();
    for (int i = 0; i < LOSS_CNT; i++) step(1, 1, rnd_byte(), 0, rnd_byte());
    step(1, 0, 8'h00, 0, 8'h00);
  endtask

  initial begin
    int align_cycles;
    bit sync_seen;
    bit seen_align;
    logic [7:0] lane1_seq [7];
    int err_before;

    model_reset();
    reset = 1'b0; enable = 1'b0;
    valid_8b_0 = 1'b0; valid_8b_1 = 1'b0; data_8b_0 = 8'h00; data_8b_1 = 8'h00;
    #2;
    check("reset_outputs", 32'({ctrl_state, lane_lock, sincronizar_bus, link_up, err_count}), 32'd0);
    @(posedge clk_4f); #1;
    reset = 1'b1;

    // Training: IDLE->SEARCH, four COM pairs lock both lanes, then ALIGN and ACTIVE.
    step(1, 0, 8'h00, 0, 8'h00);
    check("search_entry", 32'(ctrl_state), 32'd1);
    for (int i = 0; i < LOCK_CNT; i++) step(1, 1, COM, 1, COM);
    check("lock_after_4", 32'(lane_lock), 32'd3);
    step(1, 1, COM, 1, COM);
    check("align_entry", 32'(ctrl_state), 32'd2);
    step(1, 1, COM, 1, COM);
    check("active_state", 32'(ctrl_state), 32'd3);
    check("active_sync", 32'(sincronizar_bus), 32'd1);

    // Random matched traffic keeps the link up.
    for (int i = 0; i < 40; i++) begin
      bit v;
      v = 1'($urandom);
      step(1, v, rnd_byte(), v, rnd_byte());
    end
    check("active_after_traffic", 32'(ctrl_state), 32'd3);

    // Three mismatches then a match: no loss.
    for (int i = 0; i < LOSS_CNT - 1; i++) step(1, 1, rnd_byte(), 0, rnd_byte());
    step(1, 1, rnd_byte(), 1, rnd_byte());
    check("near_loss_stays_active", 32'(ctrl_state), 32'd3);

    // Four mismatches: one LOSS cycle, then SEARCH with sync low.
    for (int i = 0; i < LOSS_CNT; i++) step(1, 0, rnd_byte(), 1, rnd_byte());
    check("loss_state", 32'(ctrl_state), 32'd4);
    check("loss_sync_low", 32'(sincronizar_bus), 32'd0);
    step(1, 0, 8'h00, 0, 8'h00);
    check("loss_to_search", 32'(ctrl_state), 32'd1);
    check("err_after_loss", 32'(err_count), ERR_EN ? 32'd1 : 32'd0);

    // Lock break on lane 1: the non-COM byte restarts its count.
    lane1_seq = '{COM, COM, 8'h55, COM, COM, COM, COM};
    for (int i = 0; i < 7; i++) begin
      step(1, 1, COM, 1, lane1_seq[i]);
      check("lane1_lock_break", 32'(lane_lock[1]), (i == 6) ? 32'd1 : 32'd0);
      check("search_hold", 32'(ctrl_state), 32'd1);
    end

    // Alternating COMs never align: ALIGN times out after ALIGN_TMO cycles.
    align_cycles = 0; sync_seen = 1'b0; seen_align = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (i[0] == 1'b0) step(1, 1, COM, 0, 8'h00);
      else              step(1, 0, 8'h00, 1, COM);
      if (sincronizar_bus) sync_seen = 1'b1;
      if (ctrl_state == 3'd2) begin
        seen_align = 1'b1;
        align_cycles++;
      end else if (seen_align) begin
        break;
      end
    end
    check("align_timeout_cycles", 32'(align_cycles), 32'(ALIGN_TMO));
    check("align_timeout_state", 32'(ctrl_state), 32'd1);
    check("align_no_sync", 32'(sync_seen), 32'd0);

    // Enable drop while in ALIGN.
    step(0, 0, 8'h00, 0, 8'h00);
    step(1, 0, 8'h00, 0, 8'h00);
    for (int i = 0; i < LOCK_CNT; i++) step(1, 1, COM, 1, COM);
    step(1, 0, 8'h00, 0, 8'h00);
    check("align_before_drop", 32'(ctrl_state), 32'd2);
    step(0, 1, COM, 1, COM);
    check("drop_to_idle", 32'(ctrl_state), 32'd0);
    check("drop_clears_lock", 32'(lane_lock), 32'd0);

    // Loss threshold and enable drop on the same edge: IDLE, no count.
    err_before = m_err;
    train_to_active();
    for (int i = 0; i < LOSS_CNT - 1; i++) step(1, 1, rnd_byte(), 0, rnd_byte());
    step(0, 1, rnd_byte(), 0, rnd_byte());
    check("loss_vs_enable_state", 32'(ctrl_state), 32'd0);
    check("loss_vs_enable_err", 32'(err_count), 32'(err_before));

    // 256 link-loss events saturate the counter.
    for (int n = 0; n < 256; n++) begin
      train_to_active();
      force_loss();
    end
    check("err_saturated", 32'(err_count), ERR_EN ? 32'hFF : 32'h00);

    // Asynchronous reset in ACTIVE clears outputs before any clock edge.
    train_to_active();
    check("active_before_reset", 32'(ctrl_state), 32'd3);
    #2 reset = 1'b0;
    #1;
    check("async_reset_outputs",
          32'({ctrl_state, lane_lock, sincronizar_bus, link_up, err_count}), 32'd0);
    model_reset();
    #1 reset = 1'b1;

    // Randomized traffic with occasional enable drops, checked against the model.
    for (int i = 0; i < 1500; i++) begin
      bit en, v0, v1;
      logic [7:0] d0, d1;
      en = ($urandom_range(0, 199) != 0);
      v0 = ($urandom_range(0, 7) != 0);
      d0 = ($urandom_range(0, 3) != 0) ? COM : rnd_byte();
      if ($urandom_range(0, 3) != 0) begin
        v1 = v0; d1 = d0;
      end else begin
        v1 = ($urandom_range(0, 7) != 0);
        d1 = ($urandom_range(0, 3) != 0) ? COM : rnd_byte();
      end
      step(en, v0, d0, v1, d1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
